// File: rtl/csr_machine_unit_pkg.sv
// Shared constants, CSR addresses and register-file types for the machine-mode CSR unit.
package csr_machine_unit_pkg;

    // CSR addresses
    localparam logic [11:0] csr_mstatus       = 12'h300;
    localparam logic [11:0] csr_misa          = 12'h301;
    localparam logic [11:0] csr_mie           = 12'h304;
    localparam logic [11:0] csr_mtvec         = 12'h305;
    localparam logic [11:0] csr_mcountinhibit = 12'h320;
    localparam logic [11:0] csr_mhpmevent3    = 12'h323;
    localparam logic [11:0] csr_mhpmevent31   = 12'h33F;
    localparam logic [11:0] csr_mscratch      = 12'h340;
    localparam logic [11:0] csr_mepc          = 12'h341;
    localparam logic [11:0] csr_mcause        = 12'h342;
    localparam logic [11:0] csr_mtval         = 12'h343;
    localparam logic [11:0] csr_mip           = 12'h344;
    localparam logic [11:0] csr_mcycle        = 12'hB00;
    localparam logic [11:0] csr_minstret      = 12'hB02;
    localparam logic [11:0] csr_mhpmcounter3  = 12'hB03;
    localparam logic [11:0] csr_mcycleh       = 12'hB80;
    localparam logic [11:0] csr_minstreth     = 12'hB82;
    localparam logic [11:0] csr_mhpmcounter3h = 12'hB83;
    localparam logic [11:0] csr_mvendorid     = 12'hF11;
    localparam logic [11:0] csr_marchid       = 12'hF12;
    localparam logic [11:0] csr_mimpid        = 12'hF13;
    localparam logic [11:0] csr_mhartid       = 12'hF14;

    localparam logic [31:0] misa_value = 32'h4000_1104;

    // Interrupt cause codes
    localparam logic [4:0] interrupt_mach_soft  = 5'd3;
    localparam logic [4:0] interrupt_mach_timer = 5'd7;
    localparam logic [4:0] interrupt_mach_ext   = 5'd11;
    localparam int unsigned interrupt_local_base = 16;

    localparam logic [1:0] priv_m = 2'b11;
    localparam logic [1:0] priv_u = 2'b00;

    typedef struct packed {
        logic        mstatus_mie;
        logic        mstatus_mpie;
        logic [1:0]  mstatus_mpp;
        logic [31:0] mie;
        logic [31:0] mip;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] mscratch;
        logic [31:0] mcountinhibit;
    } csr_machine_unit_reg_type;

    // Counter slot k -> address offset: 0 mcycle, 1 minstret (offset 2), k>=2 mhpmcounter(k+1)
    function automatic logic [11:0] counter_offset(input int unsigned k);
        return (k == 0) ? 12'd0 : 12'(k + 1);
    endfunction

    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie,
                                                 input logic [1:0] mpp);
        return {19'd0, mpp, 3'd0, mpie, 3'd0, mie, 3'd0};
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with inhibit and independent low/high word write ports.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        inhibit_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wr_data_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q, count_d;

    // A write to either half suppresses the increment; the unwritten half holds.
    always_comb begin
        count_d = count_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) count_d[31:0] = wr_data_i;
            if (wr_hi_i) count_d[63:32] = wr_data_i;
        end else if (inc_i && !inhibit_i) begin
            count_d = count_q + 64'd1;
        end
    end

    // Counter state, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_machine_unit.sv
// Machine-mode CSR file: combinational read, registered write, trap/mret sequencing, counters.
module csr_machine_unit
    import csr_machine_unit_pkg::*;
#(
    parameter int unsigned NUM_HPM     = 4,
    parameter int unsigned NUM_LIRQ    = 4,
    parameter bit          VECTORED    = 1'b1,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en_i,
    input  logic [11:0]         rd_addr_i,
    output logic [31:0]         rd_data_o,
    output logic                rd_illegal_o,
    input  logic                wr_en_i,
    input  logic [11:0]         wr_addr_i,
    input  logic [31:0]         wr_data_i,
    input  logic                valid_i,
    input  logic                exception_i,
    input  logic [3:0]          ecause_i,
    input  logic [31:0]         epc_i,
    input  logic [31:0]         etval_i,
    input  logic                mret_i,
    input  logic                meip_i,
    input  logic                mtip_i,
    input  logic                msip_i,
    input  logic [NUM_LIRQ-1:0] lirq_i,
    input  logic [NUM_HPM-1:0]  hpm_event_i,
    output logic                trap_o,
    output logic [31:0]         trap_vec_o,
    output logic                mret_out_o,
    output logic [31:0]         mepc_out_o
);

    localparam int unsigned NumCnt   = 2 + NUM_HPM;
    localparam logic [31:0] IrqMask  = 32'h0000_0888 | (((32'd1 << NUM_LIRQ) - 32'd1) << 16);
    localparam logic [31:0] InhMask  = 32'h0000_0005 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

    csr_machine_unit_reg_type reg_q, reg_d, reg_rst;
    logic [31:0] mhpmevent_q [NUM_HPM];
    logic [31:0] mhpmevent_d [NUM_HPM];
    logic [63:0] cnt [NumCnt];
    logic        trap_q, trap_d, mret_q, mret_d;
    logic [31:0] mip_in, pend, rd_val;
    logic [4:0]  irq_cause;
    logic        irq_take, rd_hit;

    // Reset image of the register file
    always_comb begin
        reg_rst             = '0;
        reg_rst.mstatus_mpp = priv_m;
        reg_rst.mtvec       = MTVEC_RESET;
    end

    // Interrupt levels as seen by mip, and the highest-priority pending cause
    always_comb begin
        mip_in                     = '0;
        mip_in[11]                 = meip_i;
        mip_in[7]                  = mtip_i;
        mip_in[3]                  = msip_i;
        mip_in[16 +: NUM_LIRQ]     = lirq_i;
        pend                       = reg_q.mip & reg_q.mie;
        irq_cause                  = 5'd0;
        for (int i = int'(NUM_LIRQ) - 1; i >= 0; i--) begin
            if (pend[interrupt_local_base + i]) irq_cause = 5'(interrupt_local_base + i);
        end
        if (pend[7])  irq_cause = interrupt_mach_timer;
        if (pend[3])  irq_cause = interrupt_mach_soft;
        if (pend[11]) irq_cause = interrupt_mach_ext;
        irq_take = valid_i && reg_q.mstatus_mie && (pend != '0);
    end

    // Next-state: software write, then trap entry / mret which override it
    always_comb begin
        reg_d       = reg_q;
        mhpmevent_d = mhpmevent_q;
        reg_d.mip   = mip_in;
        if (wr_en_i) begin
            case (wr_addr_i)
                csr_mstatus: begin
                    reg_d.mstatus_mie  = wr_data_i[3];
                    reg_d.mstatus_mpie = wr_data_i[7];
                    if (wr_data_i[12:11] == priv_m || wr_data_i[12:11] == priv_u)
                        reg_d.mstatus_mpp = wr_data_i[12:11];
                end
                csr_mie:           reg_d.mie = wr_data_i & IrqMask;
                csr_mtvec:         reg_d.mtvec = {wr_data_i[31:2], 1'b0, wr_data_i[0] & VECTORED};
                csr_mepc:          reg_d.mepc = {wr_data_i[31:2], 2'b00};
                csr_mcause:        reg_d.mcause = wr_data_i;
                csr_mtval:         reg_d.mtval = wr_data_i;
                csr_mscratch:      reg_d.mscratch = wr_data_i;
                csr_mcountinhibit: reg_d.mcountinhibit = wr_data_i & InhMask;
                default: begin
                    for (int i = 0; i < int'(NUM_HPM); i++) begin
                        if (wr_addr_i == csr_mhpmevent3 + 12'(i)) mhpmevent_d[i] = wr_data_i;
                    end
                end
            endcase
        end
        trap_d = exception_i || irq_take;
        mret_d = mret_i && !trap_d;
        if (trap_d) begin
            reg_d.mepc         = epc_i;
            reg_d.mcause       = exception_i ? {28'd0, ecause_i} : {1'b1, 26'd0, irq_cause};
            reg_d.mtval        = exception_i ? etval_i : 32'd0;
            reg_d.mstatus_mpie = reg_q.mstatus_mie;
            reg_d.mstatus_mie  = 1'b0;
            reg_d.mstatus_mpp  = priv_m;
        end else if (mret_d) begin
            reg_d.mstatus_mie  = reg_q.mstatus_mpie;
            reg_d.mstatus_mpie = 1'b1;
            reg_d.mstatus_mpp  = priv_m;
        end
    end

    // Register file and registered redirect pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_q  <= reg_rst;
            trap_q <= 1'b0;
            mret_q <= 1'b0;
            for (int i = 0; i < int'(NUM_HPM); i++) mhpmevent_q[i] <= '0;
        end else begin
            reg_q       <= reg_d;
            trap_q      <= trap_d;
            mret_q      <= mret_d;
            mhpmevent_q <= mhpmevent_d;
        end
    end

    // Counter slots: 0 mcycle, 1 minstret, 2.. mhpmcounter3..
    for (genvar k = 0; k < NumCnt; k++) begin : g_cnt
        logic inc, inh;
        if (k == 0) begin : g_cycle
            assign inc = 1'b1;
            assign inh = reg_q.mcountinhibit[0];
        end else if (k == 1) begin : g_instret
            assign inc = valid_i;
            assign inh = reg_q.mcountinhibit[2];
        end else begin : g_hpm
            assign inc = hpm_event_i[k-2] && (mhpmevent_q[k-2] != '0);
            assign inh = reg_q.mcountinhibit[k+1];
        end
        csr_counter64 u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc_i     (inc),
            .inhibit_i (inh),
            .wr_lo_i   (wr_en_i && wr_addr_i == csr_mcycle + counter_offset(k)),
            .wr_hi_i   (wr_en_i && wr_addr_i == csr_mcycleh + counter_offset(k)),
            .wr_data_i (wr_data_i),
            .count_o   (cnt[k])
        );
    end

    // Combinational read decode; counter/event ranges beyond NUM_HPM are legal and read 0
    always_comb begin
        rd_val = 32'd0;
        rd_hit = 1'b1;
        case (rd_addr_i)
            csr_mvendorid, csr_marchid, csr_mimpid, csr_mhartid: rd_val = 32'd0;
            csr_misa:          rd_val = misa_value;
            csr_mstatus:       rd_val = mstatus_pack(reg_q.mstatus_mie, reg_q.mstatus_mpie,
                                                     reg_q.mstatus_mpp);
            csr_mie:           rd_val = reg_q.mie;
            csr_mip:           rd_val = reg_q.mip;
            csr_mtvec:         rd_val = reg_q.mtvec;
            csr_mepc:          rd_val = reg_q.mepc;
            csr_mcause:        rd_val = reg_q.mcause;
            csr_mtval:         rd_val = reg_q.mtval;
            csr_mscratch:      rd_val = reg_q.mscratch;
            csr_mcountinhibit: rd_val = reg_q.mcountinhibit;
            default: begin
                rd_hit = (rd_addr_i >= csr_mhpmevent3 && rd_addr_i <= csr_mhpmevent31)
                      || ((rd_addr_i[11:5] == 7'h58 || rd_addr_i[11:5] == 7'h5C)
                          && rd_addr_i[4:0] != 5'd1);
                for (int i = 0; i < int'(NUM_HPM); i++) begin
                    if (rd_addr_i == csr_mhpmevent3 + 12'(i)) rd_val = mhpmevent_q[i];
                end
                for (int k = 0; k < int'(NumCnt); k++) begin
                    if (rd_addr_i == csr_mcycle + counter_offset(k))  rd_val = cnt[k][31:0];
                    if (rd_addr_i == csr_mcycleh + counter_offset(k)) rd_val = cnt[k][63:32];
                end
            end
        endcase
    end

    // Output drive; vectored offset applies only to interrupt causes
    always_comb begin
        rd_data_o    = rd_en_i ? rd_val : 32'd0;
        rd_illegal_o = rd_en_i && !rd_hit;
        trap_vec_o   = {reg_q.mtvec[31:2], 2'b00};
        if (reg_q.mtvec[0] && reg_q.mcause[31])
            trap_vec_o = {reg_q.mtvec[31:2], 2'b00} + {25'd0, reg_q.mcause[4:0], 2'b00};
        trap_o       = trap_q;
        mret_out_o   = mret_q;
        mepc_out_o   = reg_q.mepc;
    end

endmodule

// File: tb/tb_csr_machine_unit.sv
// Directed self-checking bench for csr_machine_unit with an expected-value queue.
module tb_csr_machine_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [11:0] rd_addr = '0, wr_addr = '0;
    logic [31:0] wr_data = '0, epc = '0, etval = '0;
    logic        valid = 1'b0, exception = 1'b0, mret = 1'b0;
    logic [3:0]  ecause = '0;
    logic        meip = 1'b0, mtip = 1'b0, msip = 1'b0;
    logic [3:0]  lirq = '0, hpm_event = '0;
    logic [31:0] rd_data, trap_vec, mepc_out;
    logic        rd_illegal, trap, mret_out;

    logic [31:0] exp_q [$];
    int          n_pass = 0;
    int          n_total = 0;

    csr_machine_unit #(
        .NUM_HPM     (4),
        .NUM_LIRQ    (4),
        .VECTORED    (1'b1),
        .MTVEC_RESET (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_illegal_o (rd_illegal),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .valid_i      (valid),
        .exception_i  (exception),
        .ecause_i     (ecause),
        .epc_i        (epc),
        .etval_i      (etval),
        .mret_i       (mret),
        .meip_i       (meip),
        .mtip_i       (mtip),
        .msip_i       (msip),
        .lirq_i       (lirq),
        .hpm_event_i  (hpm_event),
        .trap_o       (trap),
        .trap_vec_o   (trap_vec),
        .mret_out_o   (mret_out),
        .mepc_out_o   (mepc_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [11:0] addr,
                              input logic [31:0] exp, input logic exp_ill);
        logic [31:0] e;
        exp_q.push_back(exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        #1;
        e = exp_q.pop_front();
        check(tag, rd_data, e);
        check({tag, "_ill"}, {31'd0, rd_illegal}, {31'd0, exp_ill});
        rd_en = 1'b0;
    endtask

    // Trap pulse expected now; trap_vec compared against the queued target
    task automatic check_trap(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        check({tag, "_trap"}, {31'd0, trap}, 32'd1);
        check({tag, "_mret"}, {31'd0, mret_out}, 32'd0);
        check({tag, "_vec"}, trap_vec, e);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_mret", {31'd0, mret_out}, 32'd0);
        check_read("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);
        check_read("unimpl_7ff", 12'h7FF, 32'd0, 1'b1);
        check_read("misa", 12'h301, 32'h4000_1104, 1'b0);
        check_read("rst_mtvec", 12'h305, 32'd0, 1'b0);
        check_read("hpmctr_hi_idx", 12'hB1F, 32'd0, 1'b0);
        check_read("hpmevt_hi_idx", 12'h327, 32'd0, 1'b0);
        rd_addr = 12'h301;
        #1;
        check("rd_en_low", rd_data, 32'd0);

        // Field write rules
        csr_write(12'h300, 32'h0000_0800);
        check_read("mpp_s_rejected", 12'h300, 32'h0000_1800, 1'b0);
        csr_write(12'h300, 32'h0000_0000);
        check_read("mpp_u_accepted", 12'h300, 32'h0000_0000, 1'b0);
        csr_write(12'h300, 32'h0000_1800);
        csr_write(12'h341, 32'h0000_1003);
        check_read("mepc_align", 12'h341, 32'h0000_1000, 1'b0);
        csr_write(12'h305, 32'h0000_0103);
        check_read("mtvec_mode", 12'h305, 32'h0000_0101, 1'b0);
        csr_write(12'h304, 32'hFFFF_FFFF);
        check_read("mie_mask", 12'h304, 32'h000F_0888, 1'b0);
        csr_write(12'h344, 32'hFFFF_FFFF);
        check_read("mip_ro", 12'h344, 32'd0, 1'b0);

        // Low-word carry into high word
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_write(12'hB80, 32'h0000_0000);
        tick();
        check_read("wrap_lo", 12'hB00, 32'd0, 1'b0);
        check_read("wrap_hi", 12'hB80, 32'd1, 1'b0);

        // Inhibit freezes mcycle/minstret
        csr_write(12'h320, 32'h0000_0005);
        csr_write(12'hB00, 32'd0);
        csr_write(12'hB80, 32'd0);
        csr_write(12'hB02, 32'd0);
        csr_write(12'hB82, 32'd0);
        valid = 1'b1;
        repeat (100) tick();
        valid = 1'b0;
        check_read("inh_mcycle", 12'hB00, 32'd0, 1'b0);
        check_read("inh_minstret", 12'hB02, 32'd0, 1'b0);
        check_read("inh_reg", 12'h320, 32'h0000_0005, 1'b0);
        csr_write(12'h320, 32'd0);
        valid = 1'b1;
        repeat (10) tick();
        valid = 1'b0;
        check_read("resume_mcycle", 12'hB00, 32'd10, 1'b0);
        check_read("resume_minstret", 12'hB02, 32'd10, 1'b0);

        // HPM counters count only with a nonzero event selector
        csr_write(12'h323, 32'd1);
        hpm_event = 4'b0011;
        repeat (5) tick();
        hpm_event = 4'b0000;
        check_read("hpm3", 12'hB03, 32'd5, 1'b0);
        check_read("hpm4_nosel", 12'hB04, 32'd0, 1'b0);
        csr_write(12'hB83, 32'd7);
        check_read("hpm3h", 12'hB83, 32'd7, 1'b0);
        check_read("hpm3_hold", 12'hB03, 32'd5, 1'b0);

        // Machine external beats timer, vectored target
        csr_write(12'h304, 32'h0000_0880);
        csr_write(12'h300, 32'h0000_1808);
        meip = 1'b1;
        mtip = 1'b1;
        tick();
        check_read("mip_sync", 12'h344, 32'h0000_0880, 1'b0);
        valid = 1'b1;
        epc   = 32'h0000_4000;
        etval = 32'h0000_DEAD;
        exp_q.push_back(32'h0000_012C);
        tick();
        valid = 1'b0;
        meip  = 1'b0;
        mtip  = 1'b0;
        check_trap("irq_mei");
        check_read("irq_mcause", 12'h342, 32'h8000_000B, 1'b0);
        check_read("irq_mepc", 12'h341, 32'h0000_4000, 1'b0);
        check_read("irq_mtval", 12'h343, 32'd0, 1'b0);
        check_read("irq_mstatus", 12'h300, 32'h0000_1880, 1'b0);
        check("irq_mepc_out", mepc_out, 32'h0000_4000);
        tick();
        check("trap_pulse_end", {31'd0, trap}, 32'd0);

        // mret restores MIE from MPIE
        mret  = 1'b1;
        valid = 1'b1;
        tick();
        mret  = 1'b0;
        valid = 1'b0;
        check("mret_pulse", {31'd0, mret_out}, 32'd1);
        check("mret_no_trap", {31'd0, trap}, 32'd0);
        check_read("mret_mstatus", 12'h300, 32'h0000_1888, 1'b0);

        // Exception beats mret and a same-cycle mepc write
        exception = 1'b1;
        ecause    = 4'd2;
        mret      = 1'b1;
        valid     = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 12'h341;
        wr_data   = 32'h0000_5554;
        epc       = 32'h0000_2000;
        etval     = 32'h0000_0077;
        exp_q.push_back(32'h0000_0100);
        tick();
        exception = 1'b0;
        mret      = 1'b0;
        valid     = 1'b0;
        wr_en     = 1'b0;
        check_trap("exc");
        check_read("exc_mepc", 12'h341, 32'h0000_2000, 1'b0);
        check_read("exc_mcause", 12'h342, 32'h0000_0002, 1'b0);
        check_read("exc_mtval", 12'h343, 32'h0000_0077, 1'b0);
        check_read("exc_mstatus", 12'h300, 32'h0000_1880, 1'b0);

        // Local interrupt 2, then lowest index wins
        lirq = 4'b0100;
        csr_write(12'h304, 32'h0004_0000);
        csr_write(12'h300, 32'h0000_1808);
        check_read("mip_lirq", 12'h344, 32'h0004_0000, 1'b0);
        valid = 1'b1;
        epc   = 32'h0000_3000;
        exp_q.push_back(32'h0000_0148);
        tick();
        valid = 1'b0;
        lirq  = 4'b0000;
        check_trap("lirq2");
        check_read("lirq2_mcause", 12'h342, 32'h8000_0012, 1'b0);
        lirq = 4'b0101;
        csr_write(12'h304, 32'h0005_0000);
        csr_write(12'h300, 32'h0000_1808);
        valid = 1'b1;
        exp_q.push_back(32'h0000_0140);
        tick();
        valid = 1'b0;
        lirq  = 4'b0000;
        check_trap("lirq0");
        check_read("lirq0_mcause", 12'h342, 32'h8000_0010, 1'b0);

        // Reset sampled while a trap is pulsing
        exception = 1'b1;
        ecause    = 4'd5;
        exp_q.push_back(32'h0000_0100);
        tick();
        check_trap("pre_rst");
        rst = 1'b0;
        tick();
        check("rst_mid_trap", {31'd0, trap}, 32'd0);
        check_read("rst2_mstatus", 12'h300, 32'h0000_1800, 1'b0);
        check_read("rst2_mtvec", 12'h305, 32'd0, 1'b0);
        exception = 1'b0;
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
